timestep_sequencer: RTL and testbench

//  Global timestep controller for one neuron/router cell or a mesh of cells, in the router clock domain.

---
 rtl/timestep_sequencer_pkg.sv | 10 +
 rtl/timestep_sequencer_quiet_detector.sv | 18 +
 rtl/timestep_sequencer.sv | 69 ++++++
 tb/tb_timestep_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/timestep_sequencer_pkg.sv
// timestep_sequencer_pkg: shared state encodings and default step limit for the sequencer, neuron and router
package timestep_sequencer_pkg;
  localparam logic [2:0] TS_IDLE    = 3'd0;
  localparam logic [2:0] TS_START   = 3'd1;
  localparam logic [2:0] TS_COMPUTE = 3'd2;
  localparam logic [2:0] TS_DRAIN   = 3'd3;
  localparam logic [2:0] TS_GAP     = 3'd4;
  localparam logic [2:0] TS_DONE    = 3'd5;
  localparam int TS_STOP_STEP = 5;
endpackage

// File: rtl/timestep_sequencer_quiet_detector.sv
// timestep_sequencer_quiet_detector: counts consecutive idle NoC cycles; ports clk, rst, en (in DRAIN), noc_active in, drained out
module timestep_sequencer_quiet_detector #(
  parameter int QUIET_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic noc_active,
  output logic drained
);
  localparam int W = $clog2(QUIET_CYCLES + 1);
  logic [W-1:0] quiet_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) quiet_cnt <= '0;
    else quiet_cnt <= (en && !noc_active) ? quiet_cnt + W'(1) : '0;
  // drained flags the idle cycle that completes the run, so the FSM leaves on that same edge
  assign drained = en && !noc_active && quiet_cnt == W'(QUIET_CYCLES - 1);
endmodule

// File: rtl/timestep_sequencer.sv
// timestep_sequencer: issues start pulses per step, waits for neuron_done and NoC drain; ports rt_clk, rt_rst, run, neuron_done, noc_active in; start, step_count, busy, finished, overrun out
module timestep_sequencer
  import timestep_sequencer_pkg::*;
#(
  parameter int STOP_STEP       = TS_STOP_STEP,
  parameter int STEP_CNT_WIDTH  = 16,
  parameter int QUIET_CYCLES    = 16,
  parameter int MIN_STEP_CYCLES = 64,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int CYC_CNT_WIDTH   = 13
) (
  input  logic                      rt_clk,
  input  logic                      rt_rst,
  input  logic                      run,
  input  logic                      neuron_done,
  input  logic                      noc_active,
  output logic                      start,
  output logic [STEP_CNT_WIDTH-1:0] step_count,
  output logic                      busy,
  output logic                      finished,
  output logic                      overrun
);
  logic [2:0] state, nxt;
  logic [CYC_CNT_WIDTH-1:0] cyc_cnt, wd_cnt;
  logic drained, waiting, last_step;
  assign waiting = state == TS_COMPUTE || state == TS_DRAIN;
  assign last_step = STOP_STEP != 0 && step_count == STEP_CNT_WIDTH'(STOP_STEP);
  timestep_sequencer_quiet_detector #(.QUIET_CYCLES(QUIET_CYCLES)) u_quiet (
    .clk(rt_clk),
    .rst(rt_rst),
    .en(state == TS_DRAIN),
    .noc_active(noc_active),
    .drained(drained)
  );
  always_comb begin
    nxt = state;
    case (state)
      TS_IDLE:    nxt = run ? TS_START : TS_IDLE;
      TS_START:   nxt = TS_COMPUTE;
      TS_COMPUTE: nxt = neuron_done ? TS_DRAIN : TS_COMPUTE;
      TS_DRAIN:   nxt = !drained ? TS_DRAIN : last_step ? TS_DONE : !run ? TS_IDLE : TS_GAP;
      TS_GAP:     nxt = !run ? TS_IDLE : cyc_cnt >= CYC_CNT_WIDTH'(MIN_STEP_CYCLES - 1) ? TS_START : TS_GAP;
      default:    nxt = TS_DONE;
    endcase
  end
  // outputs are decoded from the next state so they line up with the state register
  // cyc_cnt and wd_cnt read 0 during the START cycle, making the start-to-start spacing exactly MIN_STEP_CYCLES
  always_ff @(posedge rt_clk or posedge rt_rst)
    if (rt_rst) begin
      state      <= TS_IDLE;
      start      <= 1'b0;
      step_count <= '0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      overrun    <= 1'b0;
      cyc_cnt    <= '0;
      wd_cnt     <= '0;
    end else begin
      state    <= nxt;
      start    <= nxt == TS_START;
      busy     <= nxt != TS_IDLE && nxt != TS_DONE;
      finished <= nxt == TS_DONE;
      if (nxt == TS_START) step_count <= step_count + STEP_CNT_WIDTH'(1);
      cyc_cnt <= nxt == TS_START ? '0 : &cyc_cnt ? cyc_cnt : cyc_cnt + CYC_CNT_WIDTH'(1);
      wd_cnt  <= nxt == TS_START ? '0 :
                 (waiting && wd_cnt != CYC_CNT_WIDTH'(TIMEOUT_CYCLES)) ? wd_cnt + CYC_CNT_WIDTH'(1) : wd_cnt;
      if (waiting && wd_cnt == CYC_CNT_WIDTH'(TIMEOUT_CYCLES - 1)) overrun <= 1'b1;
    end
endmodule

// File: tb/tb_timestep_sequencer.sv
// tb_timestep_sequencer: directed self-checking bench for timestep_sequencer
module tb_timestep_sequencer;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, neuron_done = 1'b0, noc_active = 1'b0;
  logic start, busy, finished, overrun;
  logic [15:0] step_count;
  int n_chk = 0, n_fail = 0, t = 0, t0 = 0, n_start = 0, n_dbl = 0, p, s0;
  logic prev_start = 1'b0;
  always #5 clk = ~clk;
  timestep_sequencer #(
    .STOP_STEP(5), .STEP_CNT_WIDTH(16), .QUIET_CYCLES(16),
    .MIN_STEP_CYCLES(64), .TIMEOUT_CYCLES(4096), .CYC_CNT_WIDTH(13)
  ) dut (
    .rt_clk(clk), .rt_rst(rst), .run(run), .neuron_done(neuron_done), .noc_active(noc_active),
    .start(start), .step_count(step_count), .busy(busy), .finished(finished), .overrun(overrun)
  );
  always @(negedge clk) begin
    prev_start <= start;
    if (start) n_start <= n_start + 1;
    if (start && prev_start) n_dbl <= n_dbl + 1;
  end
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1; run = 1'b0; neuron_done = 1'b0; noc_active = 1'b0;
    tick;
    rst = 1'b0;
    tick;
  endtask
  task automatic wait_start(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      tick;
      if (start) break;
    end
    chk(tag, start, 1);
    t0 = t;
  endtask
  // rel counts cycles since the last start pulse; inputs set at negedge rel act at the edge closing cycle rel
  task automatic run_step(input int done_at, input int mode, input int run_off, input int limit, output int period);
    int rel;
    period = -1;
    forever begin
      tick;
      rel = t - t0;
      if (start) begin
        period = rel;
        t0 = t;
        break;
      end
      neuron_done = rel == done_at;
      noc_active = mode == 1 ? (rel % 10 == 0 && rel >= 20 && rel <= 50) : (mode == 2 && rel == done_at);
      if (rel == run_off) run = 1'b0;
      if (rel >= limit) break;
    end
    neuron_done = 1'b0;
    noc_active = 1'b0;
  endtask
  initial begin
    tick;
    chk("rst_start", start, 0);
    chk("rst_count", step_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick; tick;
    chk("idle_busy", busy, 0);
    chk("idle_start", start, 0);
    run = 1'b1;
    wait_start("t1_first_start", 10);
    chk("t1_busy", busy, 1);
    chk("t1_cnt1", step_count, 1);
    for (int i = 2; i <= 5; i++) begin
      run_step(10, 0, -1, 100, p);
      chk($sformatf("t1_period%0d", i), p, 64);
      chk($sformatf("t1_cnt%0d", i), step_count, i);
    end
    run_step(10, 0, -1, 60, p);
    chk("t1_no_sixth", p, -1);
    chk("t1_finished", finished, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_cnt_done", step_count, 5);
    chk("t1_overrun", overrun, 0);
    s0 = n_start;
    chk("t1_nstart", s0, 5);
    repeat (100) tick;
    chk("t1_done_hold", n_start, s0);
    chk("t1_still_done", finished, 1);
    do_reset;
    run = 1'b1;
    wait_start("t2_first_start", 10);
    run_step(10, 1, -1, 200, p);
    chk("t2_noc_period", p, 68);
    run_step(50, 2, -1, 200, p);
    chk("t5_same_cycle_period", p, 68);
    chk("t5_cnt", step_count, 3);
    do_reset;
    run = 1'b1;
    wait_start("t3_first_start", 10);
    run_step(10, 0, -1, 100, p);
    chk("t3_period2", p, 64);
    run_step(10, 0, 5, 100, p);
    chk("t3_paused", p, -1);
    chk("t3_cnt_pause", step_count, 2);
    chk("t3_busy_pause", busy, 0);
    chk("t3_fin_pause", finished, 0);
    run = 1'b1;
    tick;
    chk("t3_resume_start", start, 1);
    chk("t3_resume_cnt", step_count, 3);
    t0 = t;
    run_step(10, 0, 40, 100, p);
    chk("t3_gap_pause", p, -1);
    chk("t3_gap_cnt", step_count, 3);
    chk("t3_gap_busy", busy, 0);
    do_reset;
    run = 1'b1;
    wait_start("t4_first_start", 10);
    repeat (4096) tick;
    chk("t4_overrun_before", overrun, 0);
    tick;
    chk("t4_overrun_set", overrun, 1);
    chk("t4_busy", busy, 1);
    run_step(5000, 0, -1, 6000, p);
    chk("t4_late_period", p, 5018);
    run_step(10, 0, -1, 100, p);
    chk("t4_next_period", p, 64);
    chk("t4_overrun_sticky", overrun, 1);
    chk("t4_cnt", step_count, 3);
    do_reset;
    run = 1'b1;
    wait_start("t6_first_start", 10);
    run_step(10, 0, -1, 100, p);
    run_step(10, 0, -1, 100, p);
    chk("t6_period3", p, 64);
    repeat (15) tick;
    chk("t6_busy_drain", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_cnt", step_count, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_start", start, 0);
    tick; tick;
    chk("t6_hold_start", start, 0);
    rst = 1'b0;
    tick;
    chk("t6_restart_start", start, 1);
    chk("t6_restart_cnt", step_count, 1);
    tick;
    chk("t6_no_double", n_dbl, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
